// File: rtl/cv_commit_collector_pkg.sv
// rtl/cv_commit_collector_pkg.sv - shared defaults, FSM encoding and leaf-slice helper for the commitment collector
package cv_commit_collector_pkg;

  localparam int LEAVES_DEF = 4;
  localparam int DW_DEF     = 256;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DONE    = 2'd3
  } cc_state_e;

  // MSB of leaf k inside the packed cv bus; leaf 0 sits at the top.
  function automatic int leaf_msb(input int k, input int leaves, input int dw);
    return leaves * dw - 1 - k * dw;
  endfunction

endpackage

// File: rtl/cv_commit_collector.sv
// rtl/cv_commit_collector.sv - gathers LEAVES commitment words plus salt, runs the merkle tree, registers the root
module cv_commit_collector
  import cv_commit_collector_pkg::*;
#(
  parameter int LEAVES = LEAVES_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit_valid,
  input  logic [DW-1:0]        commit_data,
  output logic                 commit_ready,
  input  logic [DW-1:0]        salt_in,
  output logic [LEAVES*DW-1:0] cv,
  output logic [DW-1:0]        salt,
  output logic                 tree_start,
  input  logic                 tree_set_end,
  input  logic [DW-1:0]        cvroot,
  output logic [DW-1:0]        root_out,
  output logic                 root_valid,
  output logic                 busy
);

  localparam int            IW       = $clog2(LEAVES) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LEAVES - 1);

  cc_state_e     state;
  cc_state_e     state_next;
  logic [IW-1:0] idx;
  logic          xfer;

  assign commit_ready = (state == ST_COLLECT);
  assign busy         = (state != ST_COLLECT);
  assign xfer         = commit_valid && commit_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: DONE waits for the tree flag to fall so a stale done cannot retrigger.
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: if (xfer && (idx == LAST_IDX)) state_next = ST_START;
      ST_START:   state_next = ST_WAIT;
      ST_WAIT:    if (tree_set_end) state_next = ST_DONE;
      ST_DONE:    if (!tree_set_end) state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  // Leaf register file and salt capture; cv/salt only change in COLLECT, so they hold through the tree run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      cv   <= '0;
      salt <= '0;
    end else if (xfer) begin
      for (int k = 0; k < LEAVES; k++) begin
        if (idx == IW'(k)) cv[leaf_msb(k, LEAVES, DW) -: DW] <= commit_data;
      end
      if (idx == '0) salt <= salt_in;
      if (idx == LAST_IDX) idx <= '0;
      else                 idx <= idx + IW'(1);
    end
  end

  // Tree handshake: start raised leaving START, dropped with the root capture; root_valid is a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tree_start <= 1'b0;
      root_out   <= '0;
      root_valid <= 1'b0;
    end else begin
      root_valid <= 1'b0;
      case (state)
        ST_START: tree_start <= 1'b1;
        ST_WAIT: begin
          if (tree_set_end) begin
            tree_start <= 1'b0;
            root_out   <= cvroot;
            root_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cv_commit_collector.sv
// tb/tb_cv_commit_collector.sv - self-checking bench for cv_commit_collector with a queue-based reference model
module tb_cv_commit_collector;

  localparam int LEAVES = 4;
  localparam int DW     = 256;

  typedef logic [DW-1:0] word_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 commit_valid;
  word_t                commit_data;
  logic                 commit_ready;
  word_t                salt_in;
  logic [LEAVES*DW-1:0] cv;
  word_t                salt;
  logic                 tree_start;
  logic                 tree_set_end;
  word_t                cvroot;
  word_t                root_out;
  logic                 root_valid;
  logic                 busy;

  cv_commit_collector #(.LEAVES(LEAVES), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .salt_in      (salt_in),
    .cv           (cv),
    .salt         (salt),
    .tree_start   (tree_start),
    .tree_set_end (tree_set_end),
    .cvroot       (cvroot),
    .root_out     (root_out),
    .root_valid   (root_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  word_t acc_q[$];
  word_t exp_leaf [LEAVES];
  word_t exp_salt;
  word_t exp_root;

  function automatic word_t leaf_of(input int k);
    return cv[(LEAVES - 1 - k) * DW +: DW];
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < LEAVES; k++) exp_leaf[k] = '0;
    exp_salt = '0;
    exp_root = '0;
    acc_q.delete();
  endtask

  task automatic check_leaves(input string p);
    for (int k = 0; k < LEAVES; k++) chk($sformatf("%s_leaf%0d", p, k), leaf_of(k), exp_leaf[k]);
    chk($sformatf("%s_salt", p), salt, exp_salt);
  endtask

  // Present one word (after gap idle cycles), wait for acceptance, update the model; valid stays high.
  task automatic send(input word_t d, input word_t s, input int gap);
    int n;
    commit_valid = 1'b0;
    repeat (gap) @(negedge clk);
    commit_valid = 1'b1;
    commit_data  = d;
    salt_in      = s;
    n = 0;
    while (!commit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", word_t'(n < 200), word_t'(1));
    @(negedge clk);
    if (acc_q.size() == 0) exp_salt = s;
    acc_q.push_back(d);
    if (acc_q.size() == LEAVES) begin
      for (int k = 0; k < LEAVES; k++) exp_leaf[k] = acc_q[k];
      acc_q.delete();
    end
  endtask

  // Called right after the last transfer: START cycle first, tree_start on the following one.
  task automatic start_check();
    chk("start_gap_tree_start", word_t'(tree_start), word_t'(0));
    chk("start_busy", word_t'(busy), word_t'(1));
    chk("start_ready", word_t'(commit_ready), word_t'(0));
    @(negedge clk);
    chk("tree_start_rise", word_t'(tree_start), word_t'(1));
  endtask

  // Behave as the merkle tree: done after lat cycles, flag held for hold extra cycles.
  task automatic tree_run(input word_t root, input int lat, input int hold);
    int bad;
    int rv;
    bad = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (!tree_start || commit_ready || !busy) bad++;
    end
    chk("wait_hold_bad_cycles", word_t'(bad), word_t'(0));
    tree_set_end = 1'b1;
    cvroot       = root;
    exp_root     = root;
    @(negedge clk);
    chk("root_out", root_out, exp_root);
    chk("root_valid_pulse", word_t'(root_valid), word_t'(1));
    chk("tree_start_drop", word_t'(tree_start), word_t'(0));
    rv     = int'(root_valid);
    cvroot = rand_word();
    bad    = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rv += int'(root_valid);
      if (!busy || commit_ready || tree_start) bad++;
    end
    chk("done_hold_bad_cycles", word_t'(bad), word_t'(0));
    tree_set_end = 1'b0;
    commit_valid = 1'b0;
    @(negedge clk);
    rv += int'(root_valid);
    chk("root_valid_count", word_t'(rv), word_t'(1));
    chk("back_collect_busy", word_t'(busy), word_t'(0));
    chk("back_collect_ready", word_t'(commit_ready), word_t'(1));
    chk("root_out_held", root_out, exp_root);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t s0;
    reset        = 1'b1;
    commit_valid = 1'b0;
    commit_data  = '0;
    salt_in      = '0;
    tree_set_end = 1'b0;
    cvroot       = '0;
    model_reset();
    repeat (2) @(negedge clk);

    check_leaves("reset");
    chk("reset_root_out", root_out, word_t'(0));
    chk("reset_tree_start", word_t'(tree_start), word_t'(0));
    chk("reset_root_valid", word_t'(root_valid), word_t'(0));
    chk("reset_busy", word_t'(busy), word_t'(0));
    chk("reset_ready", word_t'(commit_ready), word_t'(1));
    reset = 1'b0;

    // Done flag while collecting is ignored.
    tree_set_end = 1'b1;
    repeat (3) @(negedge clk);
    chk("stale_done_busy", word_t'(busy), word_t'(0));
    chk("stale_done_root_valid", word_t'(root_valid), word_t'(0));
    chk("stale_done_tree_start", word_t'(tree_start), word_t'(0));
    tree_set_end = 1'b0;
    @(negedge clk);

    // Directed set: four patterned words, valid held through WAIT, long tree, long done flag.
    send({64{4'h1}}, {64{4'hA}}, 0);
    send({64{4'h2}}, {64{4'hA}}, 0);
    send({64{4'h3}}, {64{4'hA}}, 0);
    send({64{4'h4}}, {64{4'hA}}, 0);
    commit_data = {64{4'h9}};
    start_check();
    check_leaves("directed");
    tree_run({8{32'hDEADBEEF}}, 40, 10);
    check_leaves("directed_no_fifth");

    // Reset after two words: partial leaves are discarded.
    send(rand_word(), rand_word(), 1);
    send(rand_word(), rand_word(), 0);
    commit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_leaves("midcollect_reset");
    chk("midcollect_reset_ready", word_t'(commit_ready), word_t'(1));
    @(negedge clk);
    reset = 1'b0;
    s0 = rand_word();
    send({64{4'h5}}, s0, 0);
    send({64{4'h6}}, rand_word(), 0);
    send({64{4'h7}}, rand_word(), 1);
    send({64{4'h8}}, rand_word(), 0);
    commit_valid = 1'b0;
    start_check();
    check_leaves("after_reset");
    chk("after_reset_leaf0", leaf_of(0), {64{4'h5}});
    tree_run(rand_word(), 3, 0);

    // Reset during WAIT drops tree_start at once and clears everything.
    for (int k = 0; k < LEAVES; k++) send(rand_word(), rand_word(), 0);
    commit_valid = 1'b0;
    start_check();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midwait_reset_tree_start", word_t'(tree_start), word_t'(0));
    chk("midwait_reset_busy", word_t'(busy), word_t'(0));
    chk("midwait_reset_root", root_out, word_t'(0));
    check_leaves("midwait_reset");
    @(negedge clk);
    reset = 1'b0;

    // Randomised signatures: random data, salt changing every word, random gaps and tree timing.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < LEAVES; k++) send(rand_word(), rand_word(), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) commit_data = rand_word();
      else commit_valid = 1'b0;
      start_check();
      check_leaves($sformatf("rand%0d", r));
      tree_run(rand_word(), $urandom_range(1, 20), $urandom_range(0, 5));
      check_leaves($sformatf("rand%0d_post", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv_commit_collector.md
CV_COMMIT_COLLECTOR -- requirements
Module: cv_commit_collector

Interface
REQ-001 SHALL have parameter LEAVES, default 4, meaning number of commitments per tree.
REQ-002 SHALL have parameter DW, default 256, meaning commitment, salt and root width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port commit_valid, input, 1, upstream commitment-hash word present.
REQ-006 SHALL have port commit_data, input, DW, commitment-hash word.
REQ-007 SHALL have port commit_ready, output, 1, collector accepts a word this cycle.
REQ-008 SHALL have port salt_in, input, DW, per-signature salt.
REQ-009 SHALL have port cv, output, LEAVES*DW, packed commitments to the merkle tree.
REQ-010 SHALL have port salt, output, DW, salt latched for the tree.
REQ-011 SHALL have port tree_start, output, 1, request to the merkle tree.
REQ-012 SHALL have port tree_set_end, input, 1, tree-done flag from the merkle tree.
REQ-013 SHALL have port cvroot, input, DW, root from the merkle tree.
REQ-014 SHALL have port root_out, output, DW, registered root.
REQ-015 SHALL have port root_valid, output, 1, one-cycle pulse when root_out updates.
REQ-016 SHALL have port busy, output, 1, high in any state except COLLECT.

Function
REQ-017 FSM SHALL have states COLLECT, START, WAIT, DONE.
REQ-018 Transfer SHALL occur when commit_valid and commit_ready are both high on a rising edge.
REQ-019 commit_ready SHALL be high only in COLLECT.
REQ-020 Leaf index idx SHALL be a ceil(log2(LEAVES))+1-bit counter.
- Transfer k (0-based) SHALL be written to cv[LEAVES*DW-1-k*DW -: DW], so leaf 0 occupies the MSBs.
REQ-021 On transfer with idx==0, salt SHALL latch salt_in in the same cycle.
REQ-022 On transfer with idx==LEAVES-1: idx SHALL clear to 0 and the FSM SHALL enter START on the next cycle.
- No further word SHALL be accepted that cycle.
REQ-023 START SHALL assert tree_start and go to WAIT unconditionally after one cycle.
REQ-024 In WAIT, tree_start SHALL stay high, and cv and salt SHALL be held stable until tree_set_end==1 is sampled.
REQ-025 On tree_set_end==1 in WAIT:
- root_out SHALL capture cvroot;
- tree_start SHALL drop on the same edge;
- FSM SHALL enter DONE.
REQ-026 DONE SHALL pulse root_valid for exactly one cycle.
- DONE SHALL return to COLLECT only once tree_set_end==0 is sampled, so a stale done flag cannot retrigger.
- root_valid SHALL NOT repeat while waiting.
REQ-027 commit_valid outside COLLECT SHALL be ignored; no data loss is implied, because upstream must hold the word until ready.
REQ-028 tree_set_end==1 sampled in COLLECT or START SHALL be ignored.
REQ-029 Total latency SHALL be 2 cycles from the last transfer edge to tree_start high, plus the tree latency, plus 1 cycle to root_valid.
REQ-030 No arithmetic beyond the idx increment; idx SHALL never exceed LEAVES-1.

Reset
REQ-031 While reset is high, outputs SHALL be:
- cv=0, salt=0, root_out=0;
- tree_start=0, root_valid=0, busy=0;
- commit_ready=1, idx=0, state=COLLECT.
REQ-032 Reset asserted mid-collection or mid-WAIT SHALL discard partial leaves and drop tree_start asynchronously.
- The first accepted word after release SHALL be leaf 0.

Structure
REQ-033 A shared package SHALL hold:
- LEAVES and DW defaults;
- the FSM state encoding (2-bit enum);
- the leaf-slice helper constant LEAF_MSB(k)=LEAVES*DW-1-k*DW.
REQ-034 The block SHALL be a single module with no sub-modules; the leaf register file is inline.

Verification
REQ-035 Reset, then 4 words 0x11..1, 0x22..2, 0x33..3, 0x44..4 with salt_in=0xAA..A:
- cv={0x11..1,0x22..2,0x33..3,0x44..4}, salt=0xAA..A;
- tree_start high 2 cycles after the 4th transfer.
REQ-036 Model tree returns tree_set_end=1 with cvroot=0xDEAD..BEEF after 40 cycles:
- root_out=0xDEAD..BEEF with one root_valid pulse;
- tree_start low the same cycle.
REQ-037 commit_valid held high continuously through WAIT: commit_ready=0, cv unchanged, no 5th leaf written.
REQ-038 Tree holds tree_set_end=1 for 10 cycles after tree_start drops:
- exactly one root_valid;
- collector re-enters COLLECT only after tree_set_end falls.
REQ-039 Reset after 2 words, then 4 new words 0x55..5 to 0x88..8: cv holds only the new words, leaf 0=0x55..5.
REQ-040 Salt changed after leaf 0: salt output keeps the value sampled with leaf 0.
